// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - button-driven execution sequencer producing a one-cycle core clock-enable
module cpu_run_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 25000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        step_btn_n,
  input  logic        run_btn_n,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic [31:0] instr_count,
  output logic        bp_hit
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PS_LAST = PW'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_STEP  = 2'b01,
    S_RUN   = 2'b10,
    S_BREAK = 2'b11
  } state_t;

  // Bit 0 is the step button, bit 1 the run/halt button.
  logic [1:0]    w_raw;
  logic [1:0]    r_s1;
  logic [1:0]    r_s2;
  logic [1:0]    r_deb;
  logic [1:0]    r_deb_prev;
  logic [DW-1:0] r_cnt [2];

  logic          w_step_ev;
  logic          w_run_ev;
  logic          w_bp_match;

  state_t        r_state;
  logic          r_cpu_en;
  logic          r_bp_hit;
  logic          r_skip;
  logic [PW-1:0] r_presc;
  logic [31:0]   r_instr_count;

  assign w_raw = {run_btn_n, step_btn_n};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1       <= 2'b11;
      r_s2       <= 2'b11;
      r_deb      <= 2'b11;
      r_deb_prev <= 2'b11;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_s1       <= w_raw;
      r_s2       <= r_s1;
      r_deb_prev <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_LAST) begin
          r_deb[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign w_step_ev  = r_deb_prev[0] & ~r_deb[0];
  assign w_run_ev   = r_deb_prev[1] & ~r_deb[1];
  assign w_bp_match = bp_en && (pc == bp_addr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_HALT;
      r_cpu_en <= 1'b0;
      r_bp_hit <= 1'b0;
      r_skip   <= 1'b0;
      r_presc  <= '0;
    end else begin
      case (r_state)
        S_HALT: begin
          r_cpu_en <= 1'b0;
          r_bp_hit <= 1'b0;
          if (w_run_ev) begin
            r_state <= S_RUN;
            r_presc <= '0;
          end else if (w_step_ev) begin
            r_state  <= S_STEP;
            r_cpu_en <= 1'b1;
          end
        end
        S_STEP: begin
          r_cpu_en <= 1'b0;
          r_bp_hit <= 1'b0;
          r_state  <= S_HALT;
        end
        S_RUN: begin
          if (w_run_ev) begin
            r_state  <= S_HALT;
            r_cpu_en <= 1'b0;
          end else if (r_presc == PS_LAST) begin
            r_presc <= '0;
            // skip lets the instruction sitting on the breakpoint execute once after resume
            if (w_bp_match && !r_skip) begin
              r_state  <= S_BREAK;
              r_bp_hit <= 1'b1;
              r_cpu_en <= 1'b0;
            end else begin
              r_cpu_en <= 1'b1;
              r_skip   <= 1'b0;
            end
          end else begin
            r_presc  <= r_presc + PW'(1);
            r_cpu_en <= 1'b0;
          end
        end
        S_BREAK: begin
          r_cpu_en <= 1'b0;
          if (w_run_ev) begin
            r_state  <= S_RUN;
            r_presc  <= '0;
            r_skip   <= 1'b1;
            r_bp_hit <= 1'b0;
          end else if (w_step_ev) begin
            r_state  <= S_STEP;
            r_cpu_en <= 1'b1;
            r_bp_hit <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_HALT;
          r_cpu_en <= 1'b0;
          r_bp_hit <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr_count <= '0;
    end else if (r_cpu_en) begin
      r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign cpu_en      = r_cpu_en;
  assign state       = r_state;
  assign instr_count = r_instr_count;
  assign bp_hit      = r_bp_hit;

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - directed vectors and corner sequences for cpu_run_controller
module tb_cpu_run_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        step_btn_n = 1'b1;
  logic        run_btn_n = 1'b1;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'h0;
  logic [31:0] pc = 32'h0;
  logic        cpu_en;
  logic [1:0]  state;
  logic [31:0] instr_count;
  logic        bp_hit;

  cpu_run_controller #(.DEBOUNCE_CYCLES(4), .RUN_DIV(5)) dut (
    .clk(clk), .reset_n(reset_n), .step_btn_n(step_btn_n), .run_btn_n(run_btn_n),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cpu_en(cpu_en), .state(state),
    .instr_count(instr_count), .bp_hit(bp_hit)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          cyc;
  int          pulses;
  int          first_c;
  int          last_c;
  int          bad_gap;
  int          double_en;
  logic        prev_en;
  logic        pc_pending;
  logic [31:0] pc_m;
  logic [31:0] last_pc;

  typedef struct {
    logic        step_n;
    logic        run_n;
    logic        exp_en;
    logic [1:0]  exp_state;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[35];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    cyc = 0; pulses = 0; first_c = -1; last_c = -1; bad_gap = 0; double_en = 0;
    prev_en = 1'b0; pc_pending = 1'b0; pc_m = 32'h0; pc = 32'h0; last_pc = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; step_btn_n = 1'b1; run_btn_n = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_model();
  endtask

  // Core model: pc advances by 4 in the cycle after each executed pulse.
  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (pc_pending) begin
        pc_m = pc_m + 32'd4;
        pc = pc_m;
      end
      pc_pending = cpu_en;
      if (cpu_en) begin
        if (prev_en) double_en++;
        pulses++;
        last_pc = pc;
        if (first_c < 0) first_c = cyc;
        else if (cyc - last_c != 5) bad_gap++;
        last_c = cyc;
      end
      prev_en = cpu_en;
    end
  endtask

  task automatic press(input bit run, input bit step, input int hold, input int tail);
    run_btn_n = ~run;
    step_btn_n = ~step;
    run_cycles(hold);
    run_btn_n = 1'b1;
    step_btn_n = 1'b1;
    run_cycles(tail);
  endtask

  initial begin
    for (int i = 0; i < 35; i++) vecs[i] = '{1'b1, 1'b1, 1'b0, 2'b00, 32'd1};
    for (int i = 0; i < 6; i++) vecs[i] = '{1'b0, 1'b1, 1'b0, 2'b00, 32'd0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 2'b01, 32'd0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 2'b00, 32'd1};
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 3; j++) vecs[15 + 4*r + j].step_n = 1'b0;

    clear_model();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("reset state", 32'(state), 32'd0);
    check("reset cpu_en", 32'(cpu_en), 32'd0);
    check("reset instr_count", instr_count, 32'd0);
    check("reset bp_hit", 32'(bp_hit), 32'd0);

    // Step latency (event at edge D+3 = 7) followed by bounce rejection.
    for (int i = 0; i < 35; i++) begin
      step_btn_n = vecs[i].step_n;
      run_btn_n  = vecs[i].run_n;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d cpu_en", i), 32'(cpu_en), 32'(vecs[i].exp_en));
      check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d instr_count", i), instr_count, vecs[i].exp_cnt);
    end

    // Free run: entry at cycle 7, pulses every 5 cycles.
    do_reset();
    press(1'b1, 1'b0, 8, 0);
    check("run entry state", 32'(state), 32'd2);
    check("run entry no pulse", 32'(pulses), 32'd0);
    for (int g = 0; g < 100 && pulses < 4; g++) run_cycles(1);
    check("run first pulse cycle", 32'(first_c), 32'd12);
    run_cycles(1);
    check("run count after 4", instr_count, 32'd4);
    // Halt latency of 7 cycles lets exactly one more pulse through.
    press(1'b1, 1'b0, 8, 16);
    check("halt state", 32'(state), 32'd0);
    check("halt pulses", 32'(pulses), 32'd5);
    check("halt instr_count", instr_count, 32'd5);
    run_cycles(20);
    check("halt no further pulses", 32'(pulses), 32'd5);
    check("run pulse spacing", 32'(bad_gap), 32'd0);
    check("run no back-to-back", 32'(double_en), 32'd0);

    // Breakpoint at 0x10, resume past it, re-break at 0x14, then single step.
    do_reset();
    bp_en = 1'b1;
    bp_addr = 32'h10;
    press(1'b1, 1'b0, 8, 0);
    run_cycles(40);
    check("bp pulses before break", 32'(pulses), 32'd4);
    check("bp state", 32'(state), 32'd3);
    check("bp hit", 32'(bp_hit), 32'd1);
    check("bp pc", pc_m, 32'h10);
    check("bp instr_count", instr_count, 32'd4);
    pulses = 0;
    press(1'b1, 1'b0, 8, 8);
    check("resume pulses", 32'(pulses), 32'd1);
    check("resume pc", last_pc, 32'h10);
    check("resume state", 32'(state), 32'd2);
    check("resume bp_hit", 32'(bp_hit), 32'd0);
    bp_addr = 32'h14;
    run_cycles(6);
    check("rebreak state", 32'(state), 32'd3);
    check("rebreak pulses", 32'(pulses), 32'd1);
    press(1'b0, 1'b1, 8, 8);
    check("break step pulses", 32'(pulses), 32'd2);
    check("break step state", 32'(state), 32'd0);
    check("break step bp_hit", 32'(bp_hit), 32'd0);
    check("break step instr_count", instr_count, 32'd6);
    bp_en = 1'b0;

    // Run and step together: run wins.
    do_reset();
    press(1'b1, 1'b1, 8, 0);
    check("both state", 32'(state), 32'd2);
    check("both no step pulse", 32'(pulses), 32'd0);

    // instr_count wrap.
    do_reset();
    force dut.r_instr_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_instr_count;
    check("preload count", instr_count, 32'hFFFF_FFFF);
    press(1'b0, 1'b1, 8, 8);
    check("wrap pulses", 32'(pulses), 32'd1);
    check("wrap count", instr_count, 32'd0);

    // Asynchronous reset while a pulse is pending.
    do_reset();
    press(1'b1, 1'b0, 8, 0);
    for (int g = 0; g < 20 && !cpu_en; g++) run_cycles(1);
    check("pre-reset cpu_en", 32'(cpu_en), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset cpu_en", 32'(cpu_en), 32'd0);
    check("async reset state", 32'(state), 32'd0);
    check("async reset bp_hit", 32'(bp_hit), 32'd0);
    check("async reset instr_count", instr_count, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
